// File: rtl/alu_ctl_pkg.sv
// Shared ALU control types and the multiplier sequencer state encoding.
package alu_ctl_pkg;
  localparam int ALU_W = 16;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctl_t;

  localparam alu_ctl_t ALU_ADD    = '{zx: 1'b0, nx: 1'b0, zy: 1'b0, ny: 1'b0, f: 1'b1, no: 1'b0};
  // x & ~0 == x
  localparam alu_ctl_t ALU_PASS_X = '{zx: 1'b0, nx: 1'b0, zy: 1'b1, ny: 1'b1, f: 1'b0, no: 1'b0};

  typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} mul_state_e;
endpackage

// File: rtl/my_alu.sv
// Combinational zx/nx/zy/ny/f/no ALU: out = f ? x+y : x&y, with optional zero/negate stages.
module my_alu
  import alu_ctl_pkg::*;
(
  input  logic [ALU_W-1:0] x,
  input  logic [ALU_W-1:0] y,
  input  alu_ctl_t         ctl,
  output logic [ALU_W-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [ALU_W-1:0] xz, xn, yz, yn, fo;

  always_comb begin
    xz  = ctl.zx ? '0 : x;
    xn  = ctl.nx ? ~xz : xz;
    yz  = ctl.zy ? '0 : y;
    yn  = ctl.ny ? ~yz : yz;
    fo  = ctl.f ? (xn + yn) : (xn & yn);
    out = ctl.no ? ~fo : fo;
    zr  = (out == '0);
    ng  = out[ALU_W-1];
  end
endmodule

// File: rtl/alu_mul_seq.sv
// Start/done shift-and-add multiplier; one shared my_alu performs both the
// accumulate (acc+mcand) and the multiplicand doubling (mcand+mcand).
module alu_mul_seq
  import alu_ctl_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);
  mul_state_e   state_q, state_d;
  logic [W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, product_q, product_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d, done_q, done_d;

  logic [W-1:0] alu_x, alu_out;
  logic         alu_zr_unused, alu_ng_unused;

  assign alu_x = (state_q == ADD) ? acc_q : mcand_q;

  my_alu u_alu (
    .x   (alu_x),
    .y   (mcand_q),
    .ctl (ALU_ADD),
    .out (alu_out),
    .zr  (alu_zr_unused),
    .ng  (alu_ng_unused)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: if (start) begin
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = ADD;
      end
      ADD: begin
        if (mplier_q[0]) acc_d = alu_out;
        state_d = DBL;
      end
      DBL: begin
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        // acc is already final here, so product latches on the DONE-entering edge
        if (mplier_d == '0 || cnt_q == 4'd15) begin
          state_d   = DONE;
          product_d = acc_q;
        end else begin
          state_d = ADD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q == ADD || state_q == DBL)) begin
      state_d   = IDLE;
      product_d = product_q;
    end
    busy_d = (state_d == ADD) || (state_d == DBL);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq against an arithmetic product/latency model.
module tb_alu_mul_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done;
  logic [15:0] product;
  int          n_chk = 0, n_fail = 0;

  int          r_lat, r_busy;
  logic [15:0] r_prod;
  logic        r_done_after;

  always #5 clk = ~clk;

  alu_mul_seq #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int ref_lat(input logic [15:0] bb);
    int n = 1;
    for (int i = 0; i < 16; i++) if (bb[i]) n = i + 1;
    return 2 * n;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
    int unsigned p;
    p = int'(x) * int'(y);
    return p[15:0];
  endfunction

  // Issue one op from IDLE; measure edges to done, busy cycles, product, and done one cycle later.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input int hold_start,
                        input bit abort_w_start);
    a = ia; b = ib; start = 1'b1; abort = abort_w_start;
    step();
    abort = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    r_lat = -1; r_busy = 0;
    for (int k = 0; k <= 40; k++) begin
      start = (k < hold_start);
      if (done) begin r_lat = k; break; end
      if (busy) r_busy++;
      step();
    end
    start = 1'b0;
    r_prod = product;
    step();
    r_done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 16'h1234; b = 16'h5678;
    step(); step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_chk++; if (product !== 16'h0) begin n_fail++; $display("FAIL reset_product got=%h exp=0000", product); end
    start = 1'b0; rst_n = 1'b1;
    step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_held got busy=%b exp=0", busy); end
  endtask

  task automatic test_plan();
    logic [15:0] va [5] = '{16'd3, 16'h1234, 16'hFFFF, 16'h0100, 16'h7FFF};
    logic [15:0] vb [5] = '{16'd5, 16'h0000, 16'h0002, 16'h0100, 16'h8001};
    logic [15:0] vp [5] = '{16'h000F, 16'h0000, 16'hFFFE, 16'h0000, 16'hFFFF};
    int          vl [5] = '{6, 2, 4, 18, 32};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], 0, 1'b0);
      n_chk++; if (r_prod !== vp[i]) begin n_fail++; $display("FAIL plan%0d_product got=%h exp=%h", i, r_prod, vp[i]); end
      n_chk++; if (r_lat != vl[i]) begin n_fail++; $display("FAIL plan%0d_latency got=%0d exp=%0d", i, r_lat, vl[i]); end
      n_chk++; if (r_busy != vl[i]) begin n_fail++; $display("FAIL plan%0d_busy got=%0d exp=%0d", i, r_busy, vl[i]); end
      n_chk++; if (r_done_after !== 1'b0) begin n_fail++; $display("FAIL plan%0d_done_pulse got=%b exp=0", i, r_done_after); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    int unsigned mask;
    for (int i = 0; i < 30; i++) begin
      mask = (32'h1 << $urandom_range(0, 16)) - 1;
      ra = 16'($urandom);
      rb = 16'($urandom & mask);
      run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      n_chk++; if (r_prod !== ref_prod(ra, rb)) begin n_fail++; $display("FAIL rand%0d_product a=%h b=%h got=%h exp=%h", i, ra, rb, r_prod, ref_prod(ra, rb)); end
      n_chk++; if (r_lat != ref_lat(rb)) begin n_fail++; $display("FAIL rand%0d_latency b=%h got=%0d exp=%0d", i, rb, r_lat, ref_lat(rb)); end
      n_chk++; if (r_busy != ref_lat(rb)) begin n_fail++; $display("FAIL rand%0d_busy b=%h got=%0d exp=%0d", i, rb, r_busy, ref_lat(rb)); end
    end
  endtask

  task automatic test_abort();
    int seen_done = 0;
    run_op(16'd3, 16'd5, 0, 1'b0);
    // start held during busy must not restart or queue
    run_op(16'd7, 16'd9, 4, 1'b0);
    n_chk++; if (r_prod !== 16'd63) begin n_fail++; $display("FAIL start_ignored_product got=%h exp=003f", r_prod); end
    n_chk++; if (r_lat != 8) begin n_fail++; $display("FAIL start_ignored_latency got=%0d exp=8", r_lat); end
    n_chk++; if (r_done_after !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL start_not_queued got done=%b busy=%b exp=0/0", r_done_after, busy); end
    run_op(16'd3, 16'd5, 0, 1'b0);
    a = 16'd7; b = 16'd9; start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle got busy=%b done=%b exp=0/0", busy, done); end
    for (int k = 0; k < 12; k++) begin if (done) seen_done++; step(); end
    n_chk++; if (seen_done != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
    n_chk++; if (product !== 16'h000F) begin n_fail++; $display("FAIL abort_product got=%h exp=000f", product); end
    abort = 1'b1; step(); abort = 1'b0;
    n_chk++; if (busy !== 1'b0 || product !== 16'h000F) begin n_fail++; $display("FAIL abort_in_idle got busy=%b product=%h exp=0/000f", busy, product); end
  endtask

  task automatic test_reset_midop();
    int seen_done = 0;
    a = 16'd5; b = 16'h00FF; start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midop_reset got busy=%b done=%b exp=0/0", busy, done); end
    n_chk++; if (product !== 16'h0) begin n_fail++; $display("FAIL midop_reset_product got=%h exp=0000", product); end
    for (int k = 0; k < 20; k++) begin if (done) seen_done++; step(); end
    n_chk++; if (seen_done != 0) begin n_fail++; $display("FAIL midop_no_done got=%0d exp=0", seen_done); end
    run_op(16'd2, 16'd3, 0, 1'b0);
    n_chk++; if (r_prod !== 16'd6) begin n_fail++; $display("FAIL after_reset_product got=%h exp=0006", r_prod); end
  endtask

  task automatic test_back_to_back();
    int lat;
    a = 16'd11; b = 16'd13; start = 1'b1; step(); start = 1'b0;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin if (done) begin lat = k; break; end step(); end
    n_chk++; if (lat != 8) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=8", lat); end
    // start and abort in DONE are both ignored
    a = 16'd4; b = 16'd4; start = 1'b1; abort = 1'b1; step(); abort = 1'b0;
    n_chk++; if (busy !== 1'b0 || product !== 16'd143) begin n_fail++; $display("FAIL b2b_done_ignores got busy=%b product=%h exp=0/008f", busy, product); end
    step(); start = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_idle got busy=%b exp=1", busy); end
    lat = -1;
    for (int k = 0; k <= 40; k++) begin if (done) begin lat = k; break; end step(); end
    n_chk++; if (lat != 6 || product !== 16'd16) begin n_fail++; $display("FAIL b2b_second got lat=%0d product=%h exp=6/0010", lat, product); end
    step();
  endtask

  initial begin
    test_reset();
    test_plan();
    test_random();
    test_abort();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
